// File: rtl/cop0_regfile.sv
// rtl/cop0_regfile.sv - CP0 register file: BadVAddr, Count/Compare timer, Status, Cause, EPC
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   raddr, rsel -> rdata         MFC0 read port, combinational
//   we, waddr, wsel, wdata       MTC0 write port, takes effect at the clock edge
//   ex_valid, ex_code, ex_pc,
//   ex_bd, ex_badva_valid,
//   ex_badva                     exception commit
//   eret_valid                   ERET clears Status.EXL
//   ext_int                      level-sensitive hardware interrupt lines
//   epc, exl, int_req            state the control FSM consumes directly
module cop0_regfile #(
  parameter int COUNT_DIV  = 2,
  parameter bit STATUS_BEV = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [4:0]  raddr,
  input  logic [2:0]  rsel,
  output logic [31:0] rdata,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [2:0]  wsel,
  input  logic [31:0] wdata,
  input  logic        ex_valid,
  input  logic [4:0]  ex_code,
  input  logic [31:0] ex_pc,
  input  logic        ex_bd,
  input  logic        ex_badva_valid,
  input  logic [31:0] ex_badva,
  input  logic        eret_valid,
  input  logic [5:0]  ext_int,
  output logic [31:0] epc,
  output logic        exl,
  output logic        int_req
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  // Last divider phase; with COUNT_DIV = 1 the phase stays 0 and every cycle ticks.
  localparam logic PHASE_LAST = (COUNT_DIV == 2);

  logic [31:0] badvaddr_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [31:0] epc_q;
  logic [7:0]  im_q;
  logic        exl_q;
  logic        ie_q;
  logic        bd_q;
  logic        ti_q;
  logic [5:0]  ip_hw_q;
  logic [1:0]  ip_sw_q;
  logic [4:0]  exc_code_q;
  logic        phase_q;

  logic [7:0]  ip;
  logic [31:0] status_rd;
  logic [31:0] cause_rd;
  logic        tick;
  logic        wr_ok;

  always_comb begin
    // IP7 shares the hardware line with the timer interrupt.
    ip        = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};
    status_rd = {9'b0, STATUS_BEV, 6'b0, im_q, 6'b0, exl_q, ie_q};
    cause_rd  = {bd_q, ti_q, 14'b0, ip, 1'b0, exc_code_q, 2'b0};
    tick      = (phase_q == PHASE_LAST);
    // An exception commit swallows any MTC0 issued in the same cycle.
    wr_ok     = we & ~ex_valid & (wsel == 3'd0);
  end

  always_comb begin
    rdata = 32'd0;
    if (rsel == 3'd0) begin
      case (raddr)
        REG_BADVADDR: rdata = badvaddr_q;
        REG_COUNT:    rdata = count_q;
        REG_COMPARE:  rdata = compare_q;
        REG_STATUS:   rdata = status_rd;
        REG_CAUSE:    rdata = cause_rd;
        REG_EPC:      rdata = epc_q;
        default:      rdata = 32'd0;
      endcase
    end
  end

  assign epc     = epc_q;
  assign exl     = exl_q;
  assign int_req = ie_q & ~exl_q & (|(ip & im_q));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      epc_q      <= 32'd0;
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_hw_q    <= 6'd0;
      ip_sw_q    <= 2'd0;
      exc_code_q <= 5'd0;
      phase_q    <= 1'b0;
    end else begin
      phase_q <= tick ? 1'b0 : ~phase_q;
      ip_hw_q <= ext_int;

      if (wr_ok && waddr == REG_COUNT) begin
        count_q <= wdata;
      end else if (tick) begin
        count_q <= count_q + 32'd1;
      end

      // A Compare write acknowledges the timer and wins over a same-cycle match.
      if (wr_ok && waddr == REG_COMPARE) begin
        compare_q <= wdata;
        ti_q      <= 1'b0;
      end else if (count_q == compare_q) begin
        ti_q <= 1'b1;
      end

      if (wr_ok && waddr == REG_STATUS) begin
        im_q  <= wdata[15:8];
        exl_q <= wdata[1];
        ie_q  <= wdata[0];
      end

      if (wr_ok && waddr == REG_CAUSE) begin
        ip_sw_q <= wdata[9:8];
      end

      if (wr_ok && waddr == REG_EPC) begin
        epc_q <= wdata;
      end

      // ERET placed after the Status write so it forces EXL low over written data.
      if (eret_valid && !ex_valid) begin
        exl_q <= 1'b0;
      end

      // Nested exceptions (EXL already set) keep the original return point.
      if (ex_valid) begin
        exl_q      <= 1'b1;
        exc_code_q <= ex_code;
        if (!exl_q) begin
          epc_q <= ex_bd ? (ex_pc - 32'd4) : ex_pc;
          bd_q  <= ex_bd;
        end
        if (ex_badva_valid) begin
          badvaddr_q <= ex_badva;
        end
      end
    end
  end

endmodule

// File: tb/tb_cop0_regfile.sv
// tb/tb_cop0_regfile.sv - directed and randomized checks of cop0_regfile against a word-level model
module tb_cop0_regfile;

  localparam int DIV = 2;
  localparam bit BEV = 1'b1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [4:0]  raddr = '0;
  logic [2:0]  rsel = '0;
  logic [31:0] rdata;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [2:0]  wsel = '0;
  logic [31:0] wdata = '0;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_code = '0;
  logic [31:0] ex_pc = '0;
  logic        ex_bd = 1'b0;
  logic        ex_badva_valid = 1'b0;
  logic [31:0] ex_badva = '0;
  logic        eret_valid = 1'b0;
  logic [5:0]  ext_int = '0;
  logic [31:0] epc;
  logic        exl;
  logic        int_req;

  int n_assert = 0;
  int n_fail = 0;

  cop0_regfile #(.COUNT_DIV(DIV), .STATUS_BEV(BEV)) dut (
    .clk(clk), .resetn(resetn),
    .raddr(raddr), .rsel(rsel), .rdata(rdata),
    .we(we), .waddr(waddr), .wsel(wsel), .wdata(wdata),
    .ex_valid(ex_valid), .ex_code(ex_code), .ex_pc(ex_pc), .ex_bd(ex_bd),
    .ex_badva_valid(ex_badva_valid), .ex_badva(ex_badva),
    .eret_valid(eret_valid), .ext_int(ext_int),
    .epc(epc), .exl(exl), .int_req(int_req)
  );

  always #5 clk = ~clk;

  // Reference model: architectural registers as full 32-bit words.
  logic [31:0] m_count, m_compare, m_status, m_epc, m_badva;
  logic        m_bd, m_ti;
  logic [4:0]  m_code;
  logic [1:0]  m_ipsw;
  logic [5:0]  m_ext;
  int unsigned m_cyc;

  function automatic logic [31:0] m_cause();
    logic [31:0] c;
    c = 32'(m_bd) << 31;
    c = c | (32'(m_ti) << 30);
    c = c | (32'(m_ext[5] | m_ti) << 15);
    c = c | (32'(m_ext[4:0]) << 10);
    c = c | (32'(m_ipsw) << 8);
    c = c | (32'(m_code) << 2);
    return c;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
    if (s != 3'd0) return 32'd0;
    case (a)
      5'd8:    return m_badva;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_intreq();
    logic [31:0] c;
    c = m_cause();
    return m_status[0] & ~m_status[1] & (|(c[15:8] & m_status[15:8]));
  endfunction

  // Applies one clock edge to the model using the inputs that were present at that edge.
  task automatic model_edge();
    logic [31:0] nc;
    logic        nt;
    logic        old_exl;
    if (!resetn) begin
      m_count = 0; m_compare = 0; m_epc = 0; m_badva = 0;
      m_status = 32'(BEV) << 22;
      m_bd = 0; m_ti = 0; m_code = 0; m_ipsw = 0; m_ext = 0; m_cyc = 0;
    end else begin
      old_exl = m_status[1];
      m_cyc = m_cyc + 1;
      nc = (m_cyc % DIV == 0) ? m_count + 1 : m_count;
      nt = m_ti | (m_count == m_compare);
      m_ext = ext_int;
      if (we && !ex_valid && wsel == 0) begin
        case (waddr)
          5'd9:  nc = wdata;
          5'd11: begin m_compare = wdata; nt = 1'b0; end
          5'd12: m_status = (wdata & 32'h0000_FF03) | (32'(BEV) << 22);
          5'd13: m_ipsw = wdata[9:8];
          5'd14: m_epc = wdata;
          default: ;
        endcase
      end
      if (eret_valid && !ex_valid) m_status[1] = 1'b0;
      if (ex_valid) begin
        if (!old_exl) begin
          m_epc = ex_bd ? ex_pc - 4 : ex_pc;
          m_bd = ex_bd;
        end
        m_status[1] = 1'b1;
        m_code = ex_code;
        if (ex_badva_valid) m_badva = ex_badva;
      end
      m_count = nc;
      m_ti = nt;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic rd(input logic [4:0] a);
    raddr = a;
    rsel = 3'd0;
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wsel = 3'd0; wdata = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    #1;
    chk({tag, "_rdata"}, rdata, m_read(raddr, rsel));
    chk({tag, "_epc"}, epc, m_epc);
    chk({tag, "_exl"}, 32'(exl), 32'(m_status[1]));
    chk({tag, "_intreq"}, 32'(int_req), 32'(m_intreq()));
  endtask

  initial begin
    // Reset
    resetn = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
    rd(5'd12); chk("rst_status", rdata, 32'h0040_0000);
    rd(5'd13); chk("rst_cause", rdata, 32'h0);
    chk("rst_intreq", 32'(int_req), 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_exl", 32'(exl), 32'd0);

    // Count wrap
    mtc0(5'd9, 32'hFFFF_FFFE);
    repeat (4) cyc();
    rd(5'd9); chk("count_wrap", rdata, 32'h0);
    chk_model("count_wrap_m");

    // Timer interrupt
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd3);
    repeat (10) cyc();
    rd(5'd13); chk("ti_set", 32'(rdata[30]), 32'd1);
    chk_model("ti_set_m");
    mtc0(5'd12, 32'h0000_8001);
    #1; chk("ti_intreq", 32'(int_req), 32'd1);
    mtc0(5'd11, 32'h8000_0000);
    rd(5'd13); chk("ti_clear", 32'(rdata[30]), 32'd0);
    chk("ti_clear_intreq", 32'(int_req), 32'd0);

    // Exception in delay slot
    ex_valid = 1'b1; ex_pc = 32'hBFC0_0100; ex_bd = 1'b1; ex_code = 5'd4;
    ex_badva_valid = 1'b1; ex_badva = 32'h0000_1003;
    cyc();
    ex_valid = 1'b0; ex_badva_valid = 1'b0;
    rd(5'd14); chk("ex_epc", rdata, 32'hBFC0_00FC);
    rd(5'd13); chk("ex_cause", rdata, 32'h8000_0010);
    rd(5'd8);  chk("ex_badva", rdata, 32'h0000_1003);
    chk("ex_exl", 32'(exl), 32'd1);
    // Nested exception keeps EPC
    ex_valid = 1'b1; ex_pc = 32'h0000_0200; ex_bd = 1'b0;
    cyc();
    ex_valid = 1'b0;
    #1; chk("ex_nested_epc", epc, 32'hBFC0_00FC);
    chk_model("ex_nested_m");

    // ERET with Status write
    eret_valid = 1'b1; we = 1'b1; waddr = 5'd12; wsel = 3'd0; wdata = 32'h0000_FF03;
    #1; chk("eret_epc_stable", epc, 32'hBFC0_00FC);
    cyc();
    eret_valid = 1'b0; we = 1'b0;
    rd(5'd12); chk("eret_status", rdata, 32'h0040_FF01);
    chk("eret_exl", 32'(exl), 32'd0);

    // Exception beats MTC0 EPC
    ex_valid = 1'b1; ex_pc = 32'h0000_0300; ex_bd = 1'b0; ex_code = 5'd8;
    we = 1'b1; waddr = 5'd14; wdata = 32'h0000_1234;
    cyc();
    ex_valid = 1'b0; we = 1'b0;
    rd(5'd14); chk("ex_over_we_epc", rdata, 32'h0000_0300);

    // Hardware interrupt on IP4
    ext_int = 6'b000100;
    mtc0(5'd12, 32'h0000_1001);
    rd(5'd13); chk("hw_ip4", 32'(rdata[12]), 32'd1);
    chk("hw_intreq", 32'(int_req), 32'd1);
    mtc0(5'd12, 32'h0000_1003);
    #1; chk("hw_exl_mask", 32'(int_req), 32'd0);
    rd(5'd15); chk("reg15_zero", rdata, 32'd0);
    chk_model("hw_m");

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic [4:0] addrs [9];
      addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd31};
      resetn = ($urandom % 150) != 0;
      we = ($urandom % 3) == 0;
      waddr = addrs[$urandom % 9];
      wsel = (($urandom % 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      wdata = ($urandom % 2) ? 32'($urandom % 16) : $urandom;
      ex_valid = ($urandom % 12) == 0;
      ex_code = 5'($urandom);
      ex_pc = $urandom;
      ex_bd = 1'($urandom);
      ex_badva_valid = 1'($urandom);
      ex_badva = $urandom;
      eret_valid = ($urandom % 8) == 0;
      ext_int = 6'($urandom);
      raddr = addrs[$urandom % 9];
      rsel = (($urandom % 6) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      chk_model("rand");
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cop0_regfile.md
Name: cop0_regfile

Overview:
- Architectural CP0 register file for the multi-cycle reference CPU.
- Serves the accesses the control FSM issues after COP0 decode:
  - MFC0 read and MTC0 write in the COP0 access state.
  - Status and EPC handling in the exception-return state.
  - Exception entry when the FSM commits a trap.
- Owns Count/Compare timer, interrupt sampling and the interrupt request the FSM polls between instructions.

Parameters:
- COUNT_DIV, 2, Count increments once every COUNT_DIV cycles; legal values 1 or 2.
- STATUS_BEV, 1, constant read value of Status.BEV (bit 22).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- raddr  in  5  MFC0 register number
- rsel  in  3  MFC0 select
- rdata  out  32  MFC0 read data, combinational from raddr/rsel
- we  in  1  MTC0 write strobe
- waddr  in  5  MTC0 register number
- wsel  in  3  MTC0 select
- wdata  in  32  MTC0 write data
- ex_valid  in  1  commit exception this cycle
- ex_code  in  5  ExcCode
- ex_pc  in  32  PC of faulting instruction
- ex_bd  in  1  faulting instruction is in a delay slot
- ex_badva_valid  in  1  load BadVAddr (AdEL/AdES)
- ex_badva  in  32  faulting address
- eret_valid  in  1  ERET executes this cycle
- ext_int  in  6  hardware interrupt lines, level-sensitive
- epc  out  32  current EPC, the ERET target
- exl  out  1  Status.EXL
- int_req  out  1  interrupt pending and enabled

Behaviour:
- Implemented registers, all select 0:
  - BadVAddr(8): read-only.
  - Count(9).
  - Compare(11).
  - Status(12): BEV bit 22 constant, IM[15:8] RW, EXL bit 1 RW, IE bit 0 RW, other bits read 0.
  - Cause(13): BD bit 31 RO, TI bit 30 RO, IP[7:2] RO, IP[1:0] RW, ExcCode[6:2] RO.
  - EPC(14): RW.
- Any other raddr or nonzero rsel reads 0; the matching write is ignored.
- Reset values: all registers 0 except Status.BEV = STATUS_BEV. Outputs after reset: epc = 0, exl = 0, int_req = 0. The Count divider phase also resets to 0.
- Read/write timing:
  - rdata is combinational.
  - A write updates the register at the clock edge.
  - A read of the same register in the same cycle returns the old value.
- Cause.IP[7:2] is recomputed every cycle:
  - IP[6:2] = ext_int[4:0]
  - IP[7] = ext_int[5] | Cause.TI
- Timer:
  - The divider counts cycles; Count += 1 (wraps mod 2^32) when the phase reaches COUNT_DIV-1.
  - TI is set in the cycle after the registered Count equals Compare and stays set until a Compare write.
  - Count MTC0 overrides the tick that cycle; divider phase is unchanged.
  - Compare MTC0 clears TI; a set condition in the same cycle is ignored.
- int_req = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM). It is combinational from registered state.
- Exception commit (ex_valid = 1):
  - If EXL = 0: EPC = ex_bd ? ex_pc-4 : ex_pc, and Cause.BD = ex_bd.
  - If EXL = 1: EPC and BD are unchanged.
  - Always: EXL = 1, ExcCode = ex_code.
  - If ex_badva_valid: BadVAddr = ex_badva.
  - Count/TI updates still occur.
- ERET (eret_valid = 1): Status.EXL = 0. epc is stable during that cycle.
- Simultaneous events, priority ex_valid > eret_valid > we:
  - ex_valid with we or eret_valid: the write and the ERET are dropped.
  - eret_valid with a Status write: the written IM/IE take effect and EXL is forced to 0.
- resetn low on any edge overrides all pending events.

Test Plan:
- Reset then read regs 12 and 13 → Status = 0x0040_0000, Cause = 0, int_req = 0.
- COUNT_DIV = 2:
  - Write Count = 0xFFFF_FFFE, idle 4 cycles → Count = 0x0000_0000 (wrap).
  - Compare = 5, Count = 3, wait → TI = 1 and Cause bit 30 = 1.
  - Status = 0x0000_8001 → int_req = 1.
  - Write Compare → TI = 0, int_req = 0.
- ex_valid, ex_pc = 0xBFC0_0100, ex_bd = 1, code 4, badva = 0x1003 → EPC = 0xBFC0_00FC, Cause = 0x8000_0010, BadVAddr = 0x1003, exl = 1. A second exception with ex_pc = 0x200 leaves EPC unchanged.
- eret_valid with MTC0 Status = 0x0000_FF03 in the same cycle → Status = 0x0040_FF01, exl = 0.
- ex_valid with MTC0 EPC = 0x1234 in the same cycle → EPC = exception value; 0x1234 is dropped.
- ext_int = 6'b000100, Status = 0x0000_1001 → IP4 set, int_req = 1. Set EXL → int_req = 0. Read reg 15 → 0.
